// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, flag bit positions and the flag vector type.
package alu_pkg;

    localparam logic [3:0] FC_AND  = 4'd0;
    localparam logic [3:0] FC_OR   = 4'd1;
    localparam logic [3:0] FC_ADD  = 4'd2;
    localparam logic [3:0] FC_ZERO = 4'd3;
    localparam logic [3:0] FC_ANDN = 4'd4;
    localparam logic [3:0] FC_ORN  = 4'd5;
    localparam logic [3:0] FC_SUB  = 4'd6;
    localparam logic [3:0] FC_SLT  = 4'd7;

    localparam int unsigned FLAG_Z   = 0;
    localparam int unsigned FLAG_N   = 1;
    localparam int unsigned FLAG_C   = 2;
    localparam int unsigned FLAG_ERR = 3;

    typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation for one ALU result: {err, c, n, z}.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned NBIT = 32
) (
    input  logic [NBIT-1:0] i_alu_data,
    input  logic            i_alu_cout,
    input  logic [3:0]      i_fc,
    output alu_flags_t      o_flags
);

    // Carry is only meaningful for ADD; codes with bit 3 set are undefined ALU ops.
    always_comb begin
        o_flags           = '0;
        o_flags[FLAG_Z]   = (i_alu_data == '0);
        o_flags[FLAG_N]   = i_alu_data[NBIT-1];
        o_flags[FLAG_C]   = (i_fc == FC_ADD) ? i_alu_cout : 1'b0;
        o_flags[FLAG_ERR] = i_fc[3];
    end

endmodule

// File: rtl/alu_result_buf.sv
// Registered ALU result stage with a 2-entry skid buffer (head + skid register).
// Optional statistics counters are built when ALU_RES_STAT_EN is defined.
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int unsigned NBIT = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [NBIT-1:0] i_alu_data,
    input  logic            i_alu_cout,
    input  logic [3:0]      i_fc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [NBIT-1:0] o_data,
    output logic [3:0]      o_flags
`ifdef ALU_RES_STAT_EN
    ,
    output logic [15:0]     o_cnt_acc,
    output logic [15:0]     o_cnt_zero
`endif
);

    logic [1:0]      count_q, count_d;
    logic [NBIT-1:0] head_data_q, head_data_d;
    logic [NBIT-1:0] skid_data_q, skid_data_d;
    alu_flags_t      head_flags_q, head_flags_d;
    alu_flags_t      skid_flags_q, skid_flags_d;
    alu_flags_t      in_flags;
    logic            push, pop;

    alu_flag_gen #(
        .NBIT (NBIT)
    ) u_flag_gen (
        .i_alu_data (i_alu_data),
        .i_alu_cout (i_alu_cout),
        .i_fc       (i_fc),
        .o_flags    (in_flags)
    );

    // Ready depends only on registered occupancy and reset, never on i_ready.
    assign o_ready = (count_q != 2'd2) && i_rstn;
    assign o_valid = (count_q != 2'd0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready && i_rstn;

    // Next-state for occupancy and the two storage registers.
    always_comb begin
        count_d      = count_q;
        head_data_d  = head_data_q;
        head_flags_d = head_flags_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_data_d  = i_alu_data;
                    head_flags_d = in_flags;
                    count_d      = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_d  = i_alu_data;
                    head_flags_d = in_flags;
                end else if (push) begin
                    skid_data_d  = i_alu_data;
                    skid_flags_d = in_flags;
                    count_d      = 2'd2;
                end else if (pop) begin
                    count_d      = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_data_d  = skid_data_q;
                    head_flags_d = skid_flags_q;
                    count_d      = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    // Storage registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            count_q      <= 2'd0;
            head_data_q  <= '0;
            head_flags_q <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
        end else begin
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_flags_q <= head_flags_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
        end
    end

    assign o_data  = head_data_q;
    assign o_flags = head_flags_q;

`ifdef ALU_RES_STAT_EN
    logic [15:0] cnt_acc_q, cnt_zero_q;

    // Accepted and zero-result counters; both wrap naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_acc_q  <= '0;
            cnt_zero_q <= '0;
        end else if (push) begin
            cnt_acc_q  <= cnt_acc_q + 16'd1;
            cnt_zero_q <= cnt_zero_q + {15'd0, in_flags[FLAG_Z]};
        end
    end

    assign o_cnt_acc  = cnt_acc_q;
    assign o_cnt_zero = cnt_zero_q;
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Randomized self-checking bench for alu_result_buf against a queue-based reference model.
module tb_alu_result_buf;

    localparam int unsigned NBIT = 32;

    logic            i_clk = 1'b0;
    logic            i_rstn = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [NBIT-1:0] i_alu_data = '0;
    logic            i_alu_cout = 1'b0;
    logic [3:0]      i_fc = 4'd0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [NBIT-1:0] o_data;
    logic [3:0]      o_flags;
`ifdef ALU_RES_STAT_EN
    logic [15:0]     o_cnt_acc;
    logic [15:0]     o_cnt_zero;
`endif

    int errors = 0;
    int checks = 0;

    alu_result_buf #(
        .NBIT (NBIT)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_data (i_alu_data),
        .i_alu_cout (i_alu_cout),
        .i_fc       (i_fc),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_flags    (o_flags)
`ifdef ALU_RES_STAT_EN
        ,
        .o_cnt_acc  (o_cnt_acc),
        .o_cnt_zero (o_cnt_zero)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference model: an in-order queue of {flags, data} plus what the head register shows.
    logic [35:0] q[$];
    logic [35:0] shown = '0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_zero = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_flags(logic [31:0] d, logic co, logic [3:0] fc);
        logic err, c, n, z;
        err = (fc >= 4'd8);
        c   = (fc == 4'd2) && co;
        n   = (d >= 32'h8000_0000);
        z   = (d == 32'd0);
        return {err, c, n, z};
    endfunction

    // One cycle: drive inputs, compare outputs with the model, then advance the model at the edge.
    task automatic step(input logic rstn, input logic vld, input logic [31:0] d,
                        input logic co, input logic [3:0] fc, input logic rdy);
        logic exp_ready, exp_valid, push, pop;
        @(negedge i_clk);
        i_rstn     = rstn;
        i_valid    = vld;
        i_alu_data = d;
        i_alu_cout = co;
        i_fc       = fc;
        i_ready    = rdy;
        #1;
        exp_ready = rstn && (q.size() < 2);
        exp_valid = (q.size() != 0);
        check("o_ready", 64'(o_ready), 64'(exp_ready));
        check("o_valid", 64'(o_valid), 64'(exp_valid));
        check("o_data", 64'(o_data), 64'(shown[31:0]));
        check("o_flags", 64'(o_flags), 64'(shown[35:32]));
`ifdef ALU_RES_STAT_EN
        check("o_cnt_acc", 64'(o_cnt_acc), 64'(m_acc));
        check("o_cnt_zero", 64'(o_cnt_zero), 64'(m_zero));
`endif
        push = vld && exp_ready;
        pop  = exp_valid && rdy && rstn;
        @(posedge i_clk);
        if (!rstn) begin
            q.delete();
            shown  = '0;
            m_acc  = '0;
            m_zero = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({ref_flags(d, co, fc), d});
                m_acc++;
                if (d == 32'd0) m_zero++;
            end
            if (q.size() != 0) shown = q[0];
        end
    endtask

    initial begin
        logic [31:0] rd;
        // Reset, then first cycle after release must be ready.
        step(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 32'h1234, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 32'd0, 1'b0, 4'd0, 1'b1);           // zero result
        step(1'b1, 1'b1, 32'h8000_0000, 1'b1, 4'd2, 1'b1);   // ADD: n, c
        step(1'b1, 1'b1, 32'h5, 1'b1, 4'd5, 1'b1);           // ORN: carry ignored
        step(1'b1, 1'b1, 32'h7, 1'b0, 4'd9, 1'b1);           // undefined code: err
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1);
        check("err_flag_seen", 64'(o_flags), 64'h8);
        // Back-pressure: A, B fill the buffer, C is refused.
        step(1'b1, 1'b1, 32'hAAAA, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 32'hBBBB, 1'b0, 4'd1, 1'b0);
        step(1'b1, 1'b1, 32'hCCCC, 1'b0, 4'd1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1);           // A leaves
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);           // B held
        step(1'b1, 1'b1, 32'hDDDD, 1'b0, 4'd6, 1'b1);        // count 1: push+pop
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
        check("swap_head", 64'(o_data), 64'hDDDD);
        step(1'b1, 1'b1, 32'h0EEE, 1'b0, 4'd0, 1'b0);        // fill to 2
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1);           // reset at count 2
        step(1'b1, 1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 32'h3, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 32'h4, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1);
`ifdef ALU_RES_STAT_EN
        check("cnt_acc_3", 64'(o_cnt_acc), 64'd3);
        check("cnt_zero_1", 64'(o_cnt_zero), 64'd1);
`endif
        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       rd = 32'd0;
                1:       rd = 32'h8000_0000;
                default: rd = $urandom;
            endcase
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), rd,
                 1'($urandom), 4'($urandom), ($urandom_range(0, 2) != 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
